// File: rtl/fetch_ctrl.sv
// Fetch sequencer: drives pc_next, keeps one instruction-memory request in flight,
// arbitrates trap/flush/jump redirects and buffers fetched words in a 2-entry FIFO.
module fetch_ctrl #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc_current,
  output logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        trap_valid,
  input  logic [31:0] trap_target,
  input  logic        flush_valid,
  input  logic [31:0] flush_target,
  input  logic        jump_valid,
  input  logic [31:0] jump_target,
  output logic [1:0]  redirect_src,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  state_t      state, state_nxt;
  logic [1:0]  count, count_nxt;
  logic [31:0] slot0_data, slot0_pc, slot1_data, slot1_pc;
  logic [31:0] target_raw, redirect_target;
  logic        redirect, accept, push, pop, start;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

  always_comb begin
    redirect_src = 2'd0;
    target_raw   = jump_target;
    if (!reset) begin
      if (trap_valid) begin
        redirect_src = 2'd3;
        target_raw   = trap_target;
      end else if (flush_valid) begin
        redirect_src = 2'd2;
        target_raw   = flush_target;
      end else if (jump_valid) begin
        redirect_src = 2'd1;
        target_raw   = jump_target;
      end
    end
  end

  assign redirect_target = word_align(target_raw);
  assign redirect        = (redirect_src != 2'd0);
  assign accept          = (state == REQ) && imem_ready;
  // A redirect kills both the response landing this cycle and any decode pop.
  assign push            = accept && !redirect;
  assign pop             = inst_valid && inst_ready && !redirect;

  always_comb begin
    if (reset)         pc_next = RESET_ADDR;
    else if (redirect) pc_next = redirect_target;
    else if (accept)   pc_next = imem_addr + 32'd4;
    else               pc_next = pc_current;
  end

  always_comb begin
    if (redirect) count_nxt = 2'd0;
    else          count_nxt = count + 2'(push) - 2'(pop);
  end

  always_comb begin
    state_nxt = IDLE;
    start     = 1'b0;
    if (reset) begin
      state_nxt = IDLE;
    end else if (state == REQ && !imem_ready) begin
      state_nxt = redirect ? DISCARD : REQ;
    end else if (state == DISCARD && !imem_ready) begin
      state_nxt = DISCARD;
    end else if (count_nxt <= 2'd1) begin
      state_nxt = REQ;
      start     = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      count     <= 2'd0;
      imem_addr <= RESET_ADDR;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (start) imem_addr <= pc_next;
    end
  end

  // FIFO storage: slot0 is the registered head, slot1 the second entry.
  always_ff @(posedge clock) begin
    if (pop) begin
      if (push && count == 2'd1) begin
        slot0_data <= imem_rdata;
        slot0_pc   <= imem_addr;
      end else begin
        slot0_data <= slot1_data;
        slot0_pc   <= slot1_pc;
      end
      if (push && count == 2'd2) begin
        slot1_data <= imem_rdata;
        slot1_pc   <= imem_addr;
      end
    end else if (push) begin
      if (count == 2'd0) begin
        slot0_data <= imem_rdata;
        slot0_pc   <= imem_addr;
      end else begin
        slot1_data <= imem_rdata;
        slot1_pc   <= imem_addr;
      end
    end
  end

  assign imem_req   = (state != IDLE);
  assign inst_valid = (count != 2'd0);
  assign inst_data  = slot0_data;
  assign inst_pc    = slot0_pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus randomized traffic, all checked
// against a transaction-level model of the fetch stream and decode FIFO.
module tb_fetch_ctrl;

  localparam logic [31:0] RST_ADDR = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_current = RST_ADDR;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic [31:0] imem_rdata;
  logic        trap_valid = 1'b0, flush_valid = 1'b0, jump_valid = 1'b0;
  logic [31:0] trap_target = '0, flush_target = '0, jump_target = '0;
  logic [1:0]  redirect_src;
  logic        inst_valid;
  logic [31:0] inst_data, inst_pc;
  logic        inst_ready = 1'b1;

  int passed = 0;
  int total  = 0;

  // model state
  logic [63:0] q[$];
  logic        pending = 1'b0, stale = 1'b0, after_rst = 1'b0;
  logic [31:0] exp_fetch = RST_ADDR, req_addr = RST_ADDR;
  int          pops = 0;

  fetch_ctrl #(.RESET_ADDR(RST_ADDR)) dut (
    .clock(clock), .reset(reset), .pc_current(pc_current), .pc_next(pc_next),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .trap_valid(trap_valid), .trap_target(trap_target),
    .flush_valid(flush_valid), .flush_target(flush_target),
    .jump_valid(jump_valid), .jump_target(jump_target),
    .redirect_src(redirect_src), .inst_valid(inst_valid), .inst_data(inst_data),
    .inst_pc(inst_pc), .inst_ready(inst_ready)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  always_ff @(posedge clock) pc_current <= pc_next;

  task automatic adv();
    @(posedge clock);
    #1;
  endtask

  // Wait for the sampling point of the current cycle and run the reference model.
  task automatic sample();
    logic [1:0]  src;
    logic [31:0] tgt, want_pcn;
    @(negedge clock);
    if (reset) begin
      total++;
      if (redirect_src !== 2'd0 || pc_next !== RST_ADDR)
        $display("FAIL model_reset_out src=%0d pc_next=%h required 0/%h", redirect_src, pc_next, RST_ADDR);
      else passed++;
      if (after_rst) begin
        total++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0)
          $display("FAIL model_reset_idle req=%b valid=%b required 0/0", imem_req, inst_valid);
        else passed++;
      end
      q.delete();
      pending = 0; stale = 0; exp_fetch = RST_ADDR; after_rst = 1;
    end else begin
      src = 2'd0; tgt = '0;
      if (trap_valid)       begin src = 2'd3; tgt = {trap_target[31:2], 2'b00};  end
      else if (flush_valid) begin src = 2'd2; tgt = {flush_target[31:2], 2'b00}; end
      else if (jump_valid)  begin src = 2'd1; tgt = {jump_target[31:2], 2'b00};  end
      total++;
      if (redirect_src !== src) $display("FAIL model_src got %0d required %0d", redirect_src, src);
      else passed++;
      total++;
      if (inst_valid !== (q.size() != 0))
        $display("FAIL model_valid got %b required %b", inst_valid, q.size() != 0);
      else passed++;
      if (q.size() != 0) begin
        total++;
        if ({inst_data, inst_pc} !== q[0])
          $display("FAIL model_head got %h/%h required %h/%h", inst_data, inst_pc, q[0][63:32], q[0][31:0]);
        else passed++;
      end
      if (after_rst) begin
        total++;
        if (imem_req !== 1'b0) $display("FAIL model_first_cycle_idle req=%b required 0", imem_req);
        else passed++;
      end else if (imem_req) begin
        if (!pending) begin
          total++;
          if (imem_addr !== exp_fetch || q.size() > 1)
            $display("FAIL model_new_req addr=%h occ=%0d required %h/<=1", imem_addr, q.size(), exp_fetch);
          else passed++;
          pending = 1; stale = 0; req_addr = exp_fetch;
        end else begin
          total++;
          if (imem_addr !== req_addr) $display("FAIL model_addr_stable got %h required %h", imem_addr, req_addr);
          else passed++;
        end
      end else begin
        total++;
        if (pending || q.size() != 2)
          $display("FAIL model_idle pending=%b occ=%0d required 0/2", pending, q.size());
        else passed++;
        pending = 0;
      end
      if (src != 0)                          want_pcn = tgt;
      else if (pending && !stale && imem_ready) want_pcn = req_addr + 32'd4;
      else                                   want_pcn = pc_current;
      total++;
      if (pc_next !== want_pcn) $display("FAIL model_pc_next got %h required %h", pc_next, want_pcn);
      else passed++;
      if (inst_valid && inst_ready && src == 0 && q.size() != 0) begin
        void'(q.pop_front());
        pops++;
      end
      if (pending && imem_ready) begin
        if (!stale && src == 0) begin
          q.push_back({mem_word(req_addr), req_addr});
          exp_fetch = req_addr + 32'd4;
        end
        pending = 0;
      end
      total++;
      if (q.size() > 2) $display("FAIL model_overflow occ=%0d required <=2", q.size());
      else passed++;
      if (src != 0) begin
        q.delete();
        exp_fetch = tgt;
        if (pending) stale = 1;
      end
      after_rst = 0;
    end
  endtask

  task automatic do_reset();
    reset = 1; trap_valid = 0; flush_valid = 0; jump_valid = 0;
    imem_ready = 1; inst_ready = 1;
    repeat (3) begin sample(); adv(); end
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; trap_valid = 1; trap_target = 32'h0000_1234; imem_ready = 1; inst_ready = 1;
    sample(); adv();
    sample();
    total++;
    if (imem_req !== 0 || inst_valid !== 0 || pc_next !== RST_ADDR || redirect_src !== 0)
      $display("FAIL reset_state req=%b valid=%b pc_next=%h src=%0d required 0/0/%h/0",
               imem_req, inst_valid, pc_next, redirect_src, RST_ADDR);
    else passed++;
    adv(); sample(); adv();
    reset = 0; trap_valid = 0;
    sample();
    total++;
    if (imem_req !== 0) $display("FAIL reset_cycle0 req=%b required 0", imem_req);
    else passed++;
    for (int k = 1; k <= 8; k++) begin
      adv(); sample();
      total++;
      if (imem_req !== 1 || imem_addr !== 32'(4 * (k - 1)) || redirect_src !== 0)
        $display("FAIL straight_req cyc%0d req=%b addr=%h required 1/%h", k, imem_req, imem_addr, 32'(4 * (k - 1)));
      else passed++;
      if (k >= 2) begin
        total++;
        if (inst_valid !== 1 || inst_pc !== 32'(4 * (k - 2)) || inst_data !== mem_word(32'(4 * (k - 2))))
          $display("FAIL straight_head cyc%0d valid=%b pc=%h required 1/%h", k, inst_valid, inst_pc, 32'(4 * (k - 2)));
        else passed++;
      end
    end
    adv();
  endtask

  task automatic test_backpressure();
    do_reset();
    inst_ready = 0;
    for (int c = 0; c <= 5; c++) begin
      sample();
      if (c < 5) adv();
    end
    total++;
    if (imem_req !== 0 || inst_valid !== 1 || inst_pc !== 32'h0)
      $display("FAIL bp_full req=%b valid=%b pc=%h required 0/1/0", imem_req, inst_valid, inst_pc);
    else passed++;
    adv(); inst_ready = 1; sample();
    total++;
    if (inst_valid !== 1 || inst_pc !== 32'h0) $display("FAIL bp_pop0 pc=%h required 0", inst_pc);
    else passed++;
    adv(); sample();
    total++;
    if (inst_pc !== 32'h4 || imem_req !== 1 || imem_addr !== 32'h8)
      $display("FAIL bp_pop1 pc=%h req=%b addr=%h required 4/1/8", inst_pc, imem_req, imem_addr);
    else passed++;
    adv(); sample();
    total++;
    if (inst_valid !== 1 || inst_pc !== 32'h8) $display("FAIL bp_resume pc=%h required 8", inst_pc);
    else passed++;
    adv();
  endtask

  task automatic test_wait_redirect();
    do_reset();
    imem_ready = 0;
    sample(); adv();
    sample();
    total++;
    if (imem_req !== 1 || imem_addr !== 32'h0) $display("FAIL wr_req req=%b addr=%h required 1/0", imem_req, imem_addr);
    else passed++;
    adv();
    flush_valid = 1; flush_target = 32'h203;
    sample();
    total++;
    if (redirect_src !== 2'd2 || pc_next !== 32'h200)
      $display("FAIL wr_flush src=%0d pc_next=%h required 2/200", redirect_src, pc_next);
    else passed++;
    adv();
    flush_valid = 0;
    sample();
    total++;
    if (imem_req !== 1 || imem_addr !== 32'h0 || inst_valid !== 0)
      $display("FAIL wr_discard req=%b addr=%h valid=%b required 1/0/0", imem_req, imem_addr, inst_valid);
    else passed++;
    adv();
    imem_ready = 1;
    sample();
    total++;
    if (imem_addr !== 32'h0 || pc_next !== 32'h200 || inst_valid !== 0)
      $display("FAIL wr_drop addr=%h pc_next=%h valid=%b required 0/200/0", imem_addr, pc_next, inst_valid);
    else passed++;
    adv(); sample();
    total++;
    if (imem_req !== 1 || imem_addr !== 32'h200 || inst_valid !== 0)
      $display("FAIL wr_restart req=%b addr=%h valid=%b required 1/200/0", imem_req, imem_addr, inst_valid);
    else passed++;
    adv(); sample();
    total++;
    if (inst_valid !== 1 || inst_pc !== 32'h200) $display("FAIL wr_new_head valid=%b pc=%h required 1/200", inst_valid, inst_pc);
    else passed++;
    adv();
  endtask

  task automatic test_simultaneous();
    do_reset();
    inst_ready = 0;
    repeat (3) begin sample(); adv(); end
    trap_valid = 1; trap_target = 32'h100;
    flush_valid = 1; flush_target = 32'h200;
    jump_valid = 1; jump_target = 32'h300;
    sample();
    total++;
    if (redirect_src !== 2'd3 || pc_next !== 32'h100 || inst_valid !== 1)
      $display("FAIL sim_arb src=%0d pc_next=%h valid=%b required 3/100/1", redirect_src, pc_next, inst_valid);
    else passed++;
    adv();
    trap_valid = 0; flush_valid = 0; jump_valid = 0; inst_ready = 1;
    sample();
    total++;
    if (inst_valid !== 0 || imem_req !== 1 || imem_addr !== 32'h100)
      $display("FAIL sim_clear valid=%b req=%b addr=%h required 0/1/100", inst_valid, imem_req, imem_addr);
    else passed++;
    adv(); sample();
    total++;
    if (inst_valid !== 1 || inst_pc !== 32'h100) $display("FAIL sim_head pc=%h required 100", inst_pc);
    else passed++;
    adv();
  endtask

  task automatic test_wrap();
    do_reset();
    repeat (2) begin sample(); adv(); end
    jump_valid = 1; jump_target = 32'hFFFF_FFFF;
    sample();
    total++;
    if (redirect_src !== 2'd1 || pc_next !== 32'hFFFF_FFFC)
      $display("FAIL wrap_jump src=%0d pc_next=%h required 1/fffffffc", redirect_src, pc_next);
    else passed++;
    adv();
    jump_valid = 0;
    sample();
    total++;
    if (imem_addr !== 32'hFFFF_FFFC || pc_next !== 32'h0 || inst_valid !== 0)
      $display("FAIL wrap_next addr=%h pc_next=%h valid=%b required fffffffc/0/0", imem_addr, pc_next, inst_valid);
    else passed++;
    adv(); sample();
    total++;
    if (imem_addr !== 32'h0 || inst_pc !== 32'hFFFF_FFFC)
      $display("FAIL wrap_fetch addr=%h pc=%h required 0/fffffffc", imem_addr, inst_pc);
    else passed++;
    adv(); sample();
    total++;
    if (inst_valid !== 1 || inst_pc !== 32'h0) $display("FAIL wrap_head pc=%h required 0", inst_pc);
    else passed++;
    adv();
  endtask

  task automatic test_reset_mid();
    do_reset();
    sample(); adv();
    sample(); adv();
    imem_ready = 0;
    sample();
    total++;
    if (imem_req !== 1 || imem_addr !== 32'h4) $display("FAIL rm_pending req=%b addr=%h required 1/4", imem_req, imem_addr);
    else passed++;
    adv();
    reset = 1; jump_valid = 1; jump_target = 32'h80;
    sample();
    total++;
    if (pc_next !== RST_ADDR || redirect_src !== 0)
      $display("FAIL rm_during pc_next=%h src=%0d required %h/0", pc_next, redirect_src, RST_ADDR);
    else passed++;
    adv();
    reset = 0; jump_valid = 0;
    sample();
    total++;
    if (imem_req !== 0 || inst_valid !== 0 || pc_next !== RST_ADDR)
      $display("FAIL rm_after req=%b valid=%b pc_next=%h required 0/0/%h", imem_req, inst_valid, pc_next, RST_ADDR);
    else passed++;
    adv();
    imem_ready = 1;
  endtask

  task automatic test_random();
    int rst_left = 0;
    int pops0;
    do_reset();
    pops0 = pops;
    for (int i = 0; i < 3000; i++) begin
      if (rst_left > 0) rst_left--;
      else if ($urandom_range(0, 399) == 0) rst_left = 2;
      reset        = (rst_left > 0);
      imem_ready   = ($urandom_range(0, 2) != 0);
      inst_ready   = ($urandom_range(0, 3) != 0);
      trap_valid   = ($urandom_range(0, 49) == 0);
      flush_valid  = ($urandom_range(0, 29) == 0);
      jump_valid   = ($urandom_range(0, 19) == 0);
      trap_target  = $urandom;
      flush_target = $urandom;
      jump_target  = $urandom;
      sample();
      adv();
    end
    reset = 0; trap_valid = 0; flush_valid = 0; jump_valid = 0;
    total++;
    if (pops - pops0 < 200) $display("FAIL rand_progress pops=%0d required >=200", pops - pops0);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_wait_redirect();
    test_simultaneous();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
